afisaj_numarator_multicifra: RTL

Parametrised countdown timer with a multiplexed multi-digit 7-segment display, the successor to the single-digit seconds display. It holds an NR_CIFRE-digit BCD count that is loaded from the control FSM and decremented once per internal 1-second tick. Digits are scanned time-multiplexed onto one shared segment bus. It sits between the traffic-light control FSM and the board display pins.

---
 rtl/afisaj_numarator_multicifra_pkg.sv | 41 ++++
 rtl/afisaj_numarator_multicifra_generator_tick.sv | 32 +++
 rtl/afisaj_numarator_multicifra.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/afisaj_numarator_multicifra_pkg.sv
// Shared definitions for the multi-digit countdown display:
// segment codes (active-low {g,f,e,d,c,b,a}), FSM encoding and BCD decoder.
package afisaj_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } stare_t;

    // Non-BCD inputs go dark rather than showing garbage.
    function automatic logic [6:0] bcd_la_7seg(input logic [3:0] cifra);
        case (cifra)
            4'd0:    bcd_la_7seg = SEG_0;
            4'd1:    bcd_la_7seg = SEG_1;
            4'd2:    bcd_la_7seg = SEG_2;
            4'd3:    bcd_la_7seg = SEG_3;
            4'd4:    bcd_la_7seg = SEG_4;
            4'd5:    bcd_la_7seg = SEG_5;
            4'd6:    bcd_la_7seg = SEG_6;
            4'd7:    bcd_la_7seg = SEG_7;
            4'd8:    bcd_la_7seg = SEG_8;
            4'd9:    bcd_la_7seg = SEG_9;
            default: bcd_la_7seg = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/afisaj_numarator_multicifra_generator_tick.sv
// Tick generator: counts enabled cycles 0..FACTOR_DIV-1 and flags the wrap.
// The count holds while enable is low so a paused period resumes in phase.
module generator_tick #(
    parameter int FACTOR_DIV = 10
) (
    input  logic clk_i,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = $clog2(FACTOR_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(FACTOR_DIV - 1);

    logic [CW-1:0] cnt;

    // Phase counter: clear wins, otherwise advance only when enabled.
    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
        end
    end

    // A clear in the same cycle suppresses a tick that would otherwise be due.
    assign tick = enable && !clear && (cnt == CNT_MAX);

endmodule

// File: rtl/afisaj_numarator_multicifra.sv
// Multi-digit BCD countdown timer with a multiplexed 7-segment display.
// Optional build macro STINGERE_ZEROURI_EN blanks leading zero digits
// (digit 0 always shown); without it every digit is displayed.
module afisaj_numarator_multicifra
    import afisaj_pkg::*;
#(
    parameter int NR_CIFRE    = 2,
    parameter int FACTOR_DIV  = 10,
    parameter int FACTOR_SCAN = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_n,
    input  logic                  incarca,
    input  logic [4*NR_CIFRE-1:0] valoare_bcd,
    input  logic                  start,
    input  logic                  enable,
    output logic [6:0]            segmente,
    output logic [NR_CIFRE-1:0]   anod,
    output logic                  puls_1_sec,
    output logic                  gata,
    output logic                  activ
);

    localparam int IW = (NR_CIFRE > 1) ? $clog2(NR_CIFRE) : 1;
    localparam int SW = (FACTOR_SCAN > 1) ? $clog2(FACTOR_SCAN) : 1;

    stare_t                     stare, stare_urm;
    logic [NR_CIFRE-1:0][3:0]   numar, numar_urm, numar_dec, valoare_clamp;
    logic                       imprumut, dec_zero;
    logic                       gata_urm;
    logic                       tick, rulare, clear_tick;
    logic [SW-1:0]              scan_cnt;
    logic [IW-1:0]              idx;
    logic [6:0]                 seg_urm;
    logic [NR_CIFRE-1:0]        anod_urm;

    // PAUSE with enable high counts too, so resuming costs no cycle of phase.
    assign rulare     = enable && ((stare == RUN) || (stare == PAUSE));
    assign clear_tick = incarca || !((stare == RUN) || (stare == PAUSE));
    assign activ      = (stare == RUN) || (stare == PAUSE);

    generator_tick #(
        .FACTOR_DIV (FACTOR_DIV)
    ) u_tick (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .clear   (clear_tick),
        .enable  (rulare),
        .tick    (tick)
    );

    // Clamp each load digit to 9 so the count is always valid BCD.
    always_comb begin
        valoare_clamp = '0;
        for (int i = 0; i < NR_CIFRE; i++) begin
            valoare_clamp[i] = (valoare_bcd[4*i +: 4] > 4'd9) ? 4'd9 : valoare_bcd[4*i +: 4];
        end
    end

    // BCD decrement: borrow ripples up from digit 0, a 0 digit wraps to 9.
    always_comb begin
        numar_dec = numar;
        imprumut  = 1'b1;
        for (int i = 0; i < NR_CIFRE; i++) begin
            if (imprumut) begin
                if (numar[i] == 4'd0) begin
                    numar_dec[i] = 4'd9;
                end else begin
                    numar_dec[i] = numar[i] - 4'd1;
                    imprumut     = 1'b0;
                end
            end
        end
        dec_zero = (numar_dec == '0);
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!reset_n) stare <= IDLE;
        else          stare <= stare_urm;
    end

    // Next state, next count and done pulse; load overrides everything.
    always_comb begin
        stare_urm = stare;
        numar_urm = numar;
        gata_urm  = 1'b0;
        if (incarca) begin
            numar_urm = valoare_clamp;
            stare_urm = IDLE;
        end else begin
            case (stare)
                IDLE: begin
                    if (start) begin
                        if (numar == '0) begin
                            stare_urm = DONE;
                            gata_urm  = 1'b1;
                        end else begin
                            stare_urm = RUN;
                        end
                    end
                end
                RUN, PAUSE: begin
                    if (tick) begin
                        numar_urm = numar_dec;
                        if (dec_zero) begin
                            stare_urm = DONE;
                            gata_urm  = 1'b1;
                        end else begin
                            stare_urm = RUN;
                        end
                    end else if (enable) begin
                        stare_urm = RUN;
                    end else begin
                        stare_urm = PAUSE;
                    end
                end
                DONE:    numar_urm = '0;
                default: stare_urm = IDLE;
            endcase
        end
    end

    // Count and the registered one-cycle pulses.
    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            numar      <= '0;
            gata       <= 1'b0;
            puls_1_sec <= 1'b0;
        end else begin
            numar      <= numar_urm;
            gata       <= gata_urm;
            puls_1_sec <= tick;
        end
    end

    // Free-running scan: dwell FACTOR_SCAN cycles per digit, wrap at the top digit.
    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SW'(FACTOR_SCAN - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == IW'(NR_CIFRE - 1)) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

`ifdef STINGERE_ZEROURI_EN
    logic [NR_CIFRE-1:0] stins;
    logic                zero_sus;

    // A digit is blank when it and every digit above it are zero; digit 0 never is.
    always_comb begin
        stins    = '0;
        zero_sus = 1'b1;
        for (int i = NR_CIFRE - 1; i > 0; i--) begin
            zero_sus = zero_sus && (numar[i] == 4'd0);
            stins[i] = zero_sus;
        end
    end

    // Segment pattern and digit select both come from the same index.
    always_comb begin
        seg_urm  = stins[idx] ? SEG_BLANK : bcd_la_7seg(numar[idx]);
        anod_urm = ~(NR_CIFRE'(1) << idx);
    end
`else
    // Segment pattern and digit select both come from the same index.
    always_comb begin
        seg_urm  = bcd_la_7seg(numar[idx]);
        anod_urm = ~(NR_CIFRE'(1) << idx);
    end
`endif

    // Display outputs registered together so anode and segments never disagree.
    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            segmente <= SEG_0;
            anod     <= ~NR_CIFRE'(1);
        end else begin
            segmente <= seg_urm;
            anod     <= anod_urm;
        end
    end

endmodule
